// File: rtl/checkpointed_history.sv
// Branch-history unit: speculative global history, committed local history table,
// and a circular checkpoint buffer for single-cycle mispredict repair.
// Optional folded global history output is enabled with `define HIST_FOLD_EN.
module checkpointed_history #(
    parameter int GLOBAL_HIST_LEN = 16,
    parameter int LOCAL_HIST_LEN  = 10,
    parameter int INDEX_LEN       = 6,
    parameter int CKPT_DEPTH      = 8,
`ifdef HIST_FOLD_EN
    parameter int FOLD_LEN        = 8,
`endif
    localparam int TAG_W          = $clog2(CKPT_DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       pred_valid,
    input  logic [INDEX_LEN-1:0]       pred_index,
    input  logic                       pred_taken,
    output logic                       pred_ready,
    output logic [TAG_W-1:0]           pred_tag,
    input  logic                       resolve_valid,
    input  logic [TAG_W-1:0]           resolve_tag,
    input  logic                       resolve_mispred,
    input  logic                       resolve_taken,
    input  logic                       commit_valid,
    input  logic [INDEX_LEN-1:0]       query_index,
    output logic [GLOBAL_HIST_LEN-1:0] global_hist,
    output logic [LOCAL_HIST_LEN-1:0]  local_hist,
    output logic [TAG_W:0]             occupancy
`ifdef HIST_FOLD_EN
    ,
    output logic [FOLD_LEN-1:0]        folded_hist
`endif
);

    localparam int TABLE_SIZE = 1 << INDEX_LEN;
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(CKPT_DEPTH);

    // Checkpoints keep only the history bits that survive the repair shift.
    logic [GLOBAL_HIST_LEN-2:0] ckpt_ghist_reg [CKPT_DEPTH];
    logic [INDEX_LEN-1:0]       ckpt_index_reg [CKPT_DEPTH];
    logic                       ckpt_taken_reg [CKPT_DEPTH];
    logic [LOCAL_HIST_LEN-1:0]  lht_reg        [TABLE_SIZE];

    logic [GLOBAL_HIST_LEN-1:0] ghist_reg, ghist_next;
    logic [TAG_W-1:0]           head_reg, head_next;
    logic [TAG_W-1:0]           tail_reg, tail_next;
    logic [TAG_W:0]             occ_reg, occ_next;

    logic [TAG_W-1:0]           resolve_dist;
    logic                       tag_live;
    logic                       mispred_req;
    logic                       do_alloc;
    logic                       do_mispred;
    logic                       do_commit;
    logic                       commit_taken;
    logic [INDEX_LEN-1:0]       commit_index;

    always_comb begin
        resolve_dist = resolve_tag - head_reg;
        tag_live     = (occ_reg != '0) && ({1'b0, resolve_dist} < occ_reg);
        mispred_req  = resolve_valid && resolve_mispred && tag_live;
        pred_ready   = !stall && (occ_reg < FULL_CNT) && !mispred_req;
        do_alloc     = pred_valid && pred_ready;
        do_mispred   = mispred_req && !stall;
        do_commit    = commit_valid && (occ_reg != '0) && !stall;
        commit_index = ckpt_index_reg[head_reg];
        // A same-cycle repair of the head entry supplies the true outcome to retirement.
        commit_taken = (do_mispred && (resolve_tag == head_reg)) ? resolve_taken
                                                                 : ckpt_taken_reg[head_reg];
    end

    always_comb begin
        ghist_next = ghist_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        occ_next   = occ_reg;
        if (do_mispred) begin
            ghist_next = {ckpt_ghist_reg[resolve_tag], resolve_taken};
            tail_next  = resolve_tag + 1'b1;
            occ_next   = {1'b0, resolve_dist} + 1'b1;
        end else if (do_alloc) begin
            ghist_next = {ghist_reg[GLOBAL_HIST_LEN-2:0], pred_taken};
            tail_next  = tail_reg + 1'b1;
            occ_next   = occ_reg + 1'b1;
        end
        if (do_commit) begin
            head_next = head_reg + 1'b1;
            occ_next  = occ_next - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghist_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            occ_reg   <= '0;
            for (int i = 0; i < CKPT_DEPTH; i++) begin
                ckpt_ghist_reg[i] <= '0;
                ckpt_index_reg[i] <= '0;
                ckpt_taken_reg[i] <= 1'b0;
            end
            for (int i = 0; i < TABLE_SIZE; i++) begin
                lht_reg[i] <= '0;
            end
        end else begin
            ghist_reg <= ghist_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            occ_reg   <= occ_next;
            if (do_alloc) begin
                ckpt_ghist_reg[tail_reg] <= ghist_reg[GLOBAL_HIST_LEN-2:0];
                ckpt_index_reg[tail_reg] <= pred_index;
                ckpt_taken_reg[tail_reg] <= pred_taken;
            end
            if (do_mispred) begin
                ckpt_taken_reg[resolve_tag] <= resolve_taken;
            end
            if (do_commit) begin
                lht_reg[commit_index] <= {lht_reg[commit_index][LOCAL_HIST_LEN-2:0], commit_taken};
            end
        end
    end

    assign pred_tag    = tail_reg;
    assign global_hist = ghist_reg;
    assign occupancy   = occ_reg;
    assign local_hist  = lht_reg[query_index];

`ifdef HIST_FOLD_EN
    localparam int NCHUNK = (GLOBAL_HIST_LEN + FOLD_LEN - 1) / FOLD_LEN;

    logic [NCHUNK*FOLD_LEN-1:0]       ghist_pad;
    logic [NCHUNK:0][FOLD_LEN-1:0]    fold_acc;
    logic [FOLD_LEN-1:0]              fold_reg;

    // Folding the next-state history keeps folded_hist in lockstep with global_hist.
    always_comb begin
        ghist_pad = '0;
        ghist_pad[GLOBAL_HIST_LEN-1:0] = ghist_next;
    end

    assign fold_acc[0] = '0;
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_fold
        assign fold_acc[gi+1] = fold_acc[gi] ^ ghist_pad[gi*FOLD_LEN +: FOLD_LEN];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fold_reg <= '0;
        end else begin
            fold_reg <= fold_acc[NCHUNK];
        end
    end

    assign folded_hist = fold_reg;
`endif

endmodule

// File: tb/tb_checkpointed_history.sv
// Directed self-checking bench for checkpointed_history (default parameters).
module tb_checkpointed_history;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        pred_valid;
    logic [5:0]  pred_index;
    logic        pred_taken;
    logic        pred_ready;
    logic [2:0]  pred_tag;
    logic        resolve_valid;
    logic [2:0]  resolve_tag;
    logic        resolve_mispred;
    logic        resolve_taken;
    logic        commit_valid;
    logic [5:0]  query_index;
    logic [15:0] global_hist;
    logic [9:0]  local_hist;
    logic [3:0]  occupancy;
`ifdef HIST_FOLD_EN
    logic [7:0]  folded_hist;
`endif

    int checks = 0;
    int errors = 0;

    checkpointed_history dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .pred_valid      (pred_valid),
        .pred_index      (pred_index),
        .pred_taken      (pred_taken),
        .pred_ready      (pred_ready),
        .pred_tag        (pred_tag),
        .resolve_valid   (resolve_valid),
        .resolve_tag     (resolve_tag),
        .resolve_mispred (resolve_mispred),
        .resolve_taken   (resolve_taken),
        .commit_valid    (commit_valid),
        .query_index     (query_index),
        .global_hist     (global_hist),
        .local_hist      (local_hist),
        .occupancy       (occupancy)
`ifdef HIST_FOLD_EN
        ,
        .folded_hist     (folded_hist)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall           = 1'b0;
        pred_valid      = 1'b0;
        pred_index      = '0;
        pred_taken      = 1'b0;
        resolve_valid   = 1'b0;
        resolve_tag     = '0;
        resolve_mispred = 1'b0;
        resolve_taken   = 1'b0;
        commit_valid    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        query_index = '0;
        reset = 1'b0;
        #3;
        checks++; if (global_hist !== 16'h0000) begin errors++; $display("FAIL reset_ghist: got %h expected %h", global_hist, 16'h0000); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d expected %0d", occupancy, 0); end
        checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected %b", pred_ready, 1'b1); end
        checks++; if (pred_tag !== 3'd0) begin errors++; $display("FAIL reset_tag: got %0d expected %0d", pred_tag, 0); end
        checks++; if (local_hist !== 10'h000) begin errors++; $display("FAIL reset_lhist: got %h expected %h", local_hist, 10'h000); end
        step();
        reset = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_alloc();
        logic [2:0] exp_tag;
        for (int i = 0; i < 3; i++) begin
            exp_tag    = 3'(i);
            pred_valid = 1'b1;
            pred_index = 6'(i);
            pred_taken = (i != 1);
            checks++; if (pred_tag !== exp_tag) begin errors++; $display("FAIL alloc_tag%0d: got %0d expected %0d", i, pred_tag, exp_tag); end
            checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL alloc_ready%0d: got %b expected %b", i, pred_ready, 1'b1); end
            step();
        end
        pred_valid = 1'b0;
        checks++; if (global_hist !== 16'h0005) begin errors++; $display("FAIL alloc_ghist: got %h expected %h", global_hist, 16'h0005); end
        checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL alloc_occ: got %0d expected %0d", occupancy, 3); end
        $display("test_alloc: ghist=%h occ=%0d", global_hist, occupancy);
    endtask

    task automatic test_mispred();
        resolve_valid   = 1'b1;
        resolve_tag     = 3'd1;
        resolve_mispred = 1'b1;
        resolve_taken   = 1'b1;
        pred_valid      = 1'b1;
        pred_taken      = 1'b0;
        #1;
        checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL mispred_ready: got %b expected %b", pred_ready, 1'b0); end
        step();
        clear_inputs();
        checks++; if (global_hist !== 16'h0003) begin errors++; $display("FAIL mispred_ghist: got %h expected %h", global_hist, 16'h0003); end
        checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL mispred_occ: got %0d expected %0d", occupancy, 2); end
        checks++; if (pred_tag !== 3'd2) begin errors++; $display("FAIL mispred_tag: got %0d expected %0d", pred_tag, 2); end
        $display("test_mispred: ghist=%h occ=%0d tag=%0d", global_hist, occupancy, pred_tag);
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pred_valid = 1'b1;
            pred_index = 6'(i);
            pred_taken = 1'b1;
            step();
        end
        checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected %b", pred_ready, 1'b0); end
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_occ: got %0d expected %0d", occupancy, 8); end
        checks++; if (global_hist !== 16'h00FF) begin errors++; $display("FAIL full_ghist: got %h expected %h", global_hist, 16'h00FF); end
        step();
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_drop_occ: got %0d expected %0d", occupancy, 8); end
        checks++; if (global_hist !== 16'h00FF) begin errors++; $display("FAIL full_drop_ghist: got %h expected %h", global_hist, 16'h00FF); end
        commit_valid = 1'b1;
        #1;
        checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL full_commit_ready: got %b expected %b", pred_ready, 1'b0); end
        step();
        commit_valid = 1'b0;
        pred_taken   = 1'b0;
        checks++; if (occupancy !== 4'd7) begin errors++; $display("FAIL full_commit_occ: got %0d expected %0d", occupancy, 7); end
        checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %b expected %b", pred_ready, 1'b1); end
        checks++; if (pred_tag !== 3'd0) begin errors++; $display("FAIL wrap_tag: got %0d expected %0d", pred_tag, 0); end
        step();
        pred_valid  = 1'b0;
        query_index = 6'd0;
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL wrap_occ: got %0d expected %0d", occupancy, 8); end
        checks++; if (pred_tag !== 3'd1) begin errors++; $display("FAIL wrap_next_tag: got %0d expected %0d", pred_tag, 1); end
        checks++; if (global_hist !== 16'h01FE) begin errors++; $display("FAIL wrap_ghist: got %h expected %h", global_hist, 16'h01FE); end
        #1;
        checks++; if (local_hist !== 10'h001) begin errors++; $display("FAIL full_commit_lhist: got %h expected %h", local_hist, 10'h001); end
        $display("test_full_wrap: occ=%0d tag=%0d ghist=%h", occupancy, pred_tag, global_hist);
    endtask

    task automatic test_commit();
        do_reset();
        query_index = 6'd5;
        pred_valid  = 1'b1;
        pred_index  = 6'd5;
        pred_taken  = 1'b0;
        step();
        pred_valid      = 1'b0;
        resolve_valid   = 1'b1;
        resolve_tag     = 3'd0;
        resolve_mispred = 1'b1;
        resolve_taken   = 1'b1;
        commit_valid    = 1'b1;
        #1;
        checks++; if (local_hist !== 10'h000) begin errors++; $display("FAIL commit_no_bypass: got %h expected %h", local_hist, 10'h000); end
        step();
        clear_inputs();
        checks++; if (local_hist !== 10'h001) begin errors++; $display("FAIL commit_bypass_lhist: got %h expected %h", local_hist, 10'h001); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL commit_bypass_occ: got %0d expected %0d", occupancy, 0); end
        checks++; if (global_hist !== 16'h0001) begin errors++; $display("FAIL commit_bypass_ghist: got %h expected %h", global_hist, 16'h0001); end
        checks++; if (pred_tag !== 3'd1) begin errors++; $display("FAIL commit_bypass_tag: got %0d expected %0d", pred_tag, 1); end
        pred_valid = 1'b1;
        pred_index = 6'd5;
        pred_taken = 1'b1;
        step();
        pred_valid   = 1'b0;
        commit_valid = 1'b1;
        step();
        commit_valid = 1'b0;
        checks++; if (local_hist !== 10'h003) begin errors++; $display("FAIL commit_lhist: got %h expected %h", local_hist, 10'h003); end
        checks++; if (global_hist !== 16'h0003) begin errors++; $display("FAIL commit_ghist: got %h expected %h", global_hist, 16'h0003); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL commit_occ: got %0d expected %0d", occupancy, 0); end
        query_index = 6'd6;
        #1;
        checks++; if (local_hist !== 10'h000) begin errors++; $display("FAIL commit_other_idx: got %h expected %h", local_hist, 10'h000); end
        // Resolve on a non-live tag must be ignored entirely.
        resolve_valid   = 1'b1;
        resolve_tag     = 3'd3;
        resolve_mispred = 1'b1;
        resolve_taken   = 1'b0;
        #1;
        checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL dead_tag_ready: got %b expected %b", pred_ready, 1'b1); end
        step();
        clear_inputs();
        checks++; if (global_hist !== 16'h0003) begin errors++; $display("FAIL dead_tag_ghist: got %h expected %h", global_hist, 16'h0003); end
        checks++; if (pred_tag !== 3'd2) begin errors++; $display("FAIL dead_tag_tag: got %0d expected %0d", pred_tag, 2); end
        $display("test_commit: lhist[5]=003 expected, ghist=%h", global_hist);
    endtask

    task automatic test_stall();
        pred_valid = 1'b1;
        pred_index = 6'd2;
        pred_taken = 1'b1;
        step();
        pred_index = 6'd3;
        pred_taken = 1'b0;
        step();
        checks++; if (global_hist !== 16'h000E) begin errors++; $display("FAIL stall_setup_ghist: got %h expected %h", global_hist, 16'h000E); end
        stall           = 1'b1;
        pred_valid      = 1'b1;
        commit_valid    = 1'b1;
        resolve_valid   = 1'b1;
        resolve_tag     = 3'd2;
        resolve_mispred = 1'b1;
        resolve_taken   = 1'b0;
        query_index     = 6'd2;
        #1;
        checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected %b", pred_ready, 1'b0); end
        step();
        step();
        checks++; if (global_hist !== 16'h000E) begin errors++; $display("FAIL stall_ghist: got %h expected %h", global_hist, 16'h000E); end
        checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL stall_occ: got %0d expected %0d", occupancy, 2); end
        checks++; if (pred_tag !== 3'd4) begin errors++; $display("FAIL stall_tag: got %0d expected %0d", pred_tag, 4); end
        checks++; if (local_hist !== 10'h000) begin errors++; $display("FAIL stall_lhist: got %h expected %h", local_hist, 10'h000); end
        clear_inputs();
        $display("test_stall: ghist=%h occ=%0d", global_hist, occupancy);
    endtask

    task automatic test_fold();
        logic [15:0] pattern;
        pattern = 16'hA5F0;
        do_reset();
        for (int i = 15; i >= 0; i--) begin
            pred_valid   = 1'b1;
            pred_taken   = pattern[i];
            commit_valid = 1'b1;
            step();
        end
        clear_inputs();
        checks++; if (global_hist !== 16'hA5F0) begin errors++; $display("FAIL fold_ghist: got %h expected %h", global_hist, 16'hA5F0); end
        checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL fold_occ: got %0d expected %0d", occupancy, 1); end
`ifdef HIST_FOLD_EN
        checks++; if (folded_hist !== 8'h55) begin errors++; $display("FAIL fold_value: got %h expected %h", folded_hist, 8'h55); end
`endif
        $display("test_fold: ghist=%h", global_hist);
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            pred_valid = 1'b1;
            pred_taken = 1'b1;
            step();
        end
        clear_inputs();
        checks++; if (occupancy !== 4'd4) begin errors++; $display("FAIL midreset_pre_occ: got %0d expected %0d", occupancy, 4); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (global_hist !== 16'h0000) begin errors++; $display("FAIL midreset_ghist: got %h expected %h", global_hist, 16'h0000); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL midreset_occ: got %0d expected %0d", occupancy, 0); end
        checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected %b", pred_ready, 1'b1); end
        checks++; if (pred_tag !== 3'd0) begin errors++; $display("FAIL midreset_tag: got %0d expected %0d", pred_tag, 0); end
        #1;
        reset = 1'b1;
        step();
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL midreset_post_occ: got %0d expected %0d", occupancy, 0); end
        $display("test_reset_midstream done");
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_mispred();
        test_full_wrap();
        test_commit();
        test_stall();
        test_fold();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
